// File: rtl/ub_pkg.sv
// ub_pkg: shared types and width helpers for the upsampling unified buffer.
//   ctrl_t     - 16-bit iteration counter value
//   ctrl_vec_t - {unused, row, col} control-variable vector (3 x ctrl_t)
//   cnt_w()    - clog2-based width of a counter/address spanning n values
package ub_pkg;
    localparam int CTRL_W = 16;
    typedef logic [CTRL_W-1:0] ctrl_t;
    typedef ctrl_t [2:0] ctrl_vec_t;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    // Widths for the default 64x64 configuration.
    localparam int DEF_ADDR_W = cnt_w(64 * 64);
    localparam int DEF_ROWS_W = cnt_w(64 + 1);
endpackage

// File: rtl/ub_iter_gen.sv
// ub_iter_gen: 2-D row-major iteration counter over W columns x H rows.
//   clk, rst_n - clock, async active-low reset
//   clr        - synchronous clear to (0,0), dominates en
//   en         - advance one point
//   col, row   - current point
//   wrap       - high when en is set on the final point (W-1, H-1)
module ub_iter_gen
    import ub_pkg::*;
#(
    parameter int W = 4,
    parameter int H = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  en,
    output ctrl_t col,
    output ctrl_t row,
    output logic  wrap
);
    logic col_end;
    assign col_end = col == ctrl_t'(W - 1);
    assign wrap    = en && col_end && row == ctrl_t'(H - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            col <= col_end ? '0 : col + ctrl_t'(1);
            if (col_end)
                row <= wrap ? '0 : row + ctrl_t'(1);
        end
    end
endmodule

// File: rtl/upsample_ub.sv
// upsample_ub: nearest-neighbour upsampling unified buffer with row-level
// producer/consumer dependence tracking.
//   clk, rst_n            - clock, async active-low reset
//   flush                 - sync clear of counters/row tracking (RAM kept)
//   wr_wen/wr_data        - write request/element, accepted with wr_ready
//   rd_ren                - read request, accepted with rd_ready
//   rd_data/rd_valid      - returned element and its valid
//   rd_ctrl_vars          - {0, out_row, out_col} of the point being issued
//   frame_done            - pulse on acceptance of the final output element
// Build option: UPSAMPLE_UB_RD_REG_EN registers rd_data/rd_valid (1-cycle
// latency); otherwise the read is combinational.
module upsample_ub
    import ub_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int IN_W    = 64,
    parameter int IN_H    = 64,
    parameter int SX_LOG2 = 1,
    parameter int SY_LOG2 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_wen,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_ren,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output ctrl_vec_t         rd_ctrl_vars,
    output logic              frame_done
);
    localparam int OUT_W = IN_W << SX_LOG2;
    localparam int OUT_H = IN_H << SY_LOG2;
    localparam int DEPTH = IN_W * IN_H;
    localparam int AW    = cnt_w(DEPTH);
    localparam int RW    = cnt_w(IN_H + 1);

    ctrl_t             wc, wr, oc, orow;
    logic              w_acc, r_acc, w_frame_end, r_frame_end, w_row_end;
    logic              wr_frame_full;
    logic [RW-1:0]     rows_done;
    logic [AW-1:0]     waddr, raddr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_ready  = !wr_frame_full;
    // Source row of the current output point must be fully written.
    assign rd_ready  = (orow >> SY_LOG2) < ctrl_t'(rows_done);
    assign w_acc     = wr_wen && wr_ready && !flush;
    assign r_acc     = rd_ren && rd_ready && !flush;
    assign w_row_end = w_acc && wc == ctrl_t'(IN_W - 1);
    assign waddr     = AW'(int'(wr) * IN_W + int'(wc));
    assign raddr     = AW'(int'(orow >> SY_LOG2) * IN_W + int'(oc >> SX_LOG2));
    assign frame_done   = r_frame_end;
    assign rd_ctrl_vars = {ctrl_t'(0), orow, oc};

    ub_iter_gen #(.W(IN_W), .H(IN_H)) u_wr_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (flush),
        .en   (w_acc),
        .col  (wc),
        .row  (wr),
        .wrap (w_frame_end)
    );

    ub_iter_gen #(.W(OUT_W), .H(OUT_H)) u_rd_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (flush),
        .en   (r_acc),
        .col  (oc),
        .row  (orow),
        .wrap (r_frame_end)
    );

    always_ff @(posedge clk) begin
        if (w_acc)
            mem[waddr] <= wr_data;
    end

    // A frame-end read cannot coincide with a row-completing write, since
    // the last row is only readable once the frame is full and writes stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_done     <= '0;
            wr_frame_full <= 1'b0;
        end else if (flush || r_frame_end) begin
            rows_done     <= '0;
            wr_frame_full <= 1'b0;
        end else begin
            if (w_row_end)
                rows_done <= rows_done + RW'(1);
            if (w_frame_end)
                wr_frame_full <= 1'b1;
        end
    end

`ifdef UPSAMPLE_UB_RD_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= r_acc;
            if (r_acc)
                rd_data <= mem[raddr];
        end
    end
`else
    // Gated so rd_data is 0 whenever no read is being accepted.
    assign rd_valid = r_acc;
    assign rd_data  = r_acc ? mem[raddr] : '0;
`endif
endmodule

// File: tb/tb_upsample_ub.sv
// tb_upsample_ub: randomized/directed bench for two upsample_ub configurations
// (4x4 scale 2x2, and 8x2 scale 4x1) against a frame-level reference model.
module tb_upsample_ub;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        wen [2];
    logic        ren [2];
    logic        fl [2];
    logic [15:0] wd [2];
    logic        wr_ready_o [2];
    logic        rd_ready_o [2];
    logic        rd_valid_o [2];
    logic        fd_o [2];
    logic [15:0] rdata_o [2];
    logic [47:0] cv_o [2];

    int IW [2] = '{4, 8};
    int IH [2] = '{4, 2};
    int SXL [2] = '{1, 2};
    int SYL [2] = '{1, 0};

    int          wcnt [2];
    int          rcnt [2];
    bit          pv [2];
    logic [15:0] pd [2];
    logic [15:0] mm [2][64];
    int          frames [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    upsample_ub #(.DATA_W(16), .IN_W(4), .IN_H(4), .SX_LOG2(1), .SY_LOG2(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]), .wr_wen(wen[0]), .wr_data(wd[0]),
        .wr_ready(wr_ready_o[0]), .rd_ren(ren[0]), .rd_ready(rd_ready_o[0]),
        .rd_data(rdata_o[0]), .rd_valid(rd_valid_o[0]), .rd_ctrl_vars(cv_o[0]),
        .frame_done(fd_o[0])
    );

    upsample_ub #(.DATA_W(16), .IN_W(8), .IN_H(2), .SX_LOG2(2), .SY_LOG2(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]), .wr_wen(wen[1]), .wr_data(wd[1]),
        .wr_ready(wr_ready_o[1]), .rd_ren(ren[1]), .rd_ready(rd_ready_o[1]),
        .rd_data(rdata_o[1]), .rd_valid(rd_valid_o[1]), .rd_ctrl_vars(cv_o[1]),
        .frame_done(fd_o[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            wen[d] = 0;
            ren[d] = 0;
            fl[d]  = 0;
            wd[d]  = '0;
        end
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%0d:rst_wr_ready", d), 64'(wr_ready_o[d]), 1);
            chk($sformatf("%0d:rst_rd_ready", d), 64'(rd_ready_o[d]), 0);
            chk($sformatf("%0d:rst_rd_valid", d), 64'(rd_valid_o[d]), 0);
            chk($sformatf("%0d:rst_rd_data", d), 64'(rdata_o[d]), 0);
            chk($sformatf("%0d:rst_ctrl_vars", d), 64'(cv_o[d]), 0);
            chk($sformatf("%0d:rst_frame_done", d), 64'(fd_o[d]), 0);
            wcnt[d] = 0;
            rcnt[d] = 0;
            pv[d]   = 0;
            pd[d]   = '0;
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    // One clock: check every output against the model, then advance the model.
    task automatic cycle();
        bit          acc_w [2];
        bit          acc_r [2];
        bit          last [2];
        logic [15:0] el [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            int ow   = IW[d] * (1 << SXL[d]);
            int tot  = IW[d] * IH[d];
            int totr = tot * (1 << SXL[d]) * (1 << SYL[d]);
            int r    = rcnt[d] / ow;
            int c    = rcnt[d] % ow;
            bit ewr  = wcnt[d] < tot;
            bit err  = (r / (1 << SYL[d])) < (wcnt[d] / IW[d]);
            acc_w[d] = wen[d] && ewr && !fl[d];
            acc_r[d] = ren[d] && err && !fl[d];
            last[d]  = acc_r[d] && rcnt[d] == totr - 1;
            el[d]    = mm[d][(r / (1 << SYL[d])) * IW[d] + c / (1 << SXL[d])];
            chk($sformatf("%0d:wr_ready", d), 64'(wr_ready_o[d]), 64'(ewr));
            chk($sformatf("%0d:rd_ready", d), 64'(rd_ready_o[d]), 64'(err));
            chk($sformatf("%0d:frame_done", d), 64'(fd_o[d]), 64'(last[d]));
            chk($sformatf("%0d:ctrl_vars", d), 64'(cv_o[d]), {16'h0, 16'h0, 16'(r), 16'(c)});
`ifdef UPSAMPLE_UB_RD_REG_EN
            chk($sformatf("%0d:rd_valid", d), 64'(rd_valid_o[d]), 64'(pv[d]));
            chk($sformatf("%0d:rd_data", d), 64'(rdata_o[d]), 64'(pd[d]));
`else
            chk($sformatf("%0d:rd_valid", d), 64'(rd_valid_o[d]), 64'(acc_r[d]));
            chk($sformatf("%0d:rd_data", d), 64'(rdata_o[d]), acc_r[d] ? 64'(el[d]) : 64'h0);
`endif
            if (fd_o[d] === 1'b1)
                frames[d]++;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (fl[d]) begin
                wcnt[d] = 0;
                rcnt[d] = 0;
                pv[d]   = 0;
            end else begin
                if (acc_w[d]) begin
                    mm[d][wcnt[d]] = wd[d];
                    wcnt[d]++;
                end
                pv[d] = acc_r[d];
                if (acc_r[d]) begin
                    pd[d] = el[d];
                    rcnt[d]++;
                end
                if (last[d]) begin
                    rcnt[d] = 0;
                    wcnt[d] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_run(input int d, input int n, input int pw, input int pr);
        for (int i = 0; i < n; i++) begin
            wen[d] = $urandom_range(99) < pw;
            ren[d] = $urandom_range(99) < pr;
            wd[d]  = 16'($urandom);
            cycle();
        end
        idle();
    endtask

    initial begin
        do_reset();
        // Frame 1 on A: values 0..15, then 64 held reads.
        for (int i = 0; i < 16; i++) begin
            wen[0] = 1;
            wd[0]  = 16'(i);
            cycle();
        end
        idle();
        ren[0] = 1;
        for (int i = 0; i < 64; i++)
            cycle();
        chk("0:frames_after_first", 64'(frames[0]), 1);
        // Read before data: only 3 of row 0 written.
        for (int i = 0; i < 3; i++) begin
            wen[0] = 1;
            wd[0]  = 16'($urandom);
            cycle();
        end
        chk("0:rd_ready_partial_row", 64'(rd_ready_o[0]), 0);
        wd[0] = 16'($urandom);
        cycle();
        chk("0:rd_ready_after_row", 64'(rd_ready_o[0]), 1);
        // Finish the frame with wr_wen held through the frame boundary.
        for (int i = 0; i < 90; i++) begin
            wd[0] = 16'($urandom);
            cycle();
        end
        chk("0:frames_after_boundary", 64'(frames[0]), 2);
        idle();
        rand_run(0, 250, 60, 70);
        // Flush mid-frame after 5 writes and 2 reads.
        fl[0] = 1;
        cycle();
        idle();
        for (int i = 0; i < 5; i++) begin
            wen[0] = 1;
            wd[0]  = 16'($urandom);
            cycle();
        end
        idle();
        ren[0] = 1;
        cycle();
        cycle();
        fl[0]  = 1;
        wen[0] = 1;
        cycle();
        fl[0] = 0;
        #1;
        chk("0:rd_ready_after_flush", 64'(rd_ready_o[0]), 0);
        chk("0:rd_valid_after_flush", 64'(rd_valid_o[0]), 0);
        wd[0] = 16'h5a5a;
        cycle();
        idle();
        rand_run(0, 300, 70, 70);
        // Reset mid-frame aborts it.
        for (int i = 0; i < 6; i++) begin
            wen[0] = 1;
            wd[0]  = 16'($urandom);
            cycle();
        end
        do_reset();
        rand_run(0, 200, 70, 70);
        // B: interleaved streaming with horizontal-only upsampling.
        rand_run(1, 500, 60, 75);
        chk("1:frames_seen_nonzero", 64'(frames[1] > 0), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/upsample_ub.md
# upsample_ub

Parametrised nearest-neighbour upsampling unified buffer. It generalises the fixed 64x64 / factor-2 buffer to configurable data width, input extent and per-axis power-of-two scale factors. It generates its own write and read iteration counters and tracks row-level dependences, so that producer and consumer stall correctly. It sits between an input-stencil producer and an output-stencil consumer in the generated accelerator.

## Interface
- DATA_W, 16, element width
- IN_W, 64, input columns (≥2)
- IN_H, 64, input rows (≥2)
- SX_LOG2, 1, log2 of horizontal scale factor (0..3)
- SY_LOG2, 1, log2 of vertical scale factor (0..3)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous: clears counters and row tracking; RAM contents are untouched
- wr_wen  in  1  write request
- wr_data  in  DATA_W  write element
- wr_ready  out  1  write accepted when wr_wen&&wr_ready
- rd_ren  in  1  read request
- rd_ready  out  1  read accepted when rd_ren&&rd_ready
- rd_data  out  DATA_W  read element
- rd_valid  out  1  rd_data valid
- rd_ctrl_vars  out  16x3  {0, out_row, out_col} of the current read point
- frame_done  out  1  one-cycle pulse when the final output element is accepted

## Operation
- Output extent: OUT_W=IN_W<<SX_LOG2 and OUT_H=IN_H<<SY_LOG2. RAM depth is IN_W*IN_H, and the address is row*IN_W+col.
- Write generator (wc, wr): row-major over IN_W×IN_H. It advances on an accepted write. At (IN_W-1, IN_H-1) it wraps to (0,0) and sets `wr_frame_full`.
- Read generator (oc, or): row-major over OUT_W×OUT_H. The read address is (or>>SY_LOG2)*IN_W + (oc>>SX_LOG2), using shifts only and no dividers. The generator advances on an accepted read.
- rows_done: count of fully written input rows, 0..IN_H. It increments when wc wraps.
- rd_ready = (or>>SY_LOG2) < rows_done.
- wr_ready = !wr_frame_full.
- End of the last output element: an accepted read at (OUT_W-1, OUT_H-1) does all of the following:
  - pulses frame_done;
  - wraps the read generator;
  - clears rows_done and wr_frame_full.
  - A write issued in that same cycle is stalled, because wr_ready is still 0.
- Simultaneous write-completing-row and read in the same cycle: the read uses the pre-increment rows_done.
- flush takes precedence over all other events in its cycle: it zeroes the generators, rows_done, wr_frame_full and rd_valid.

## Timing
- Write: data lands in the RAM at the edge of acceptance. The row becomes readable the cycle after the edge on which its last element is written.
- Read latency is 1 cycle with UPSAMPLE_UB_RD_REG_EN defined, and 0 without it (see Configuration).
- Throughput: 1 write/cycle and 1 read/cycle concurrently.
- Reset values:
  - wr_ready=1, rd_ready=0, rd_valid=0, rd_data=0, rd_ctrl_vars=0, frame_done=0;
  - all counters 0.
- Reset asserted mid-frame aborts the frame immediately. Only the RAM retains its contents.

## Configuration
- UPSAMPLE_UB_RD_REG_EN defined:
  - rd_data and rd_valid are registered, and rd_valid = the accepted read, delayed 1 cycle.
  - rd_ctrl_vars reflects the point being issued, not the returned point.
- Not defined:
  - rd_data is a combinational RAM read at the current read address.
  - rd_valid = rd_ren&&rd_ready in the same cycle, for SRAM-free simulation models.

## Structure
- Package `ub_pkg`:
  - `ctrl_t` (16-bit counter type);
  - `ctrl_vec_t` (3×ctrl_t);
  - clog2-derived width constants for address and row count.
- Sub-module `ub_iter_gen`:
  - parameterised 2-D row-major counter with enable, synchronous clear and wrap pulse;
  - instantiated twice, for the write and read domains.
- The RAM is an inferred array inside the top module, with a single write port and a single read port.

## Test plan
- Reset, then 0 cycles of stimulus. Required at reset release: wr_ready=1, rd_ready=0, rd_valid=0.
- IN 4x4, scale 2x2:
  - Stimulus: write values 0..15, then read 64 with rd_ren held.
  - Required: the output row is 0,0,1,1,2,2,3,3, and each output row repeats twice.
  - Required: frame_done pulses on read 64.
- Read before data: assert rd_ren with only 3 of the 4 row-0 elements written.
  - Required: rd_ready=0.
  - After the 4th write, rd_ready=1 on the next cycle.
- Frame boundary:
  - Stimulus: finish writing frame 1, then hold wr_wen.
  - Required: wr_ready=0 until the cycle after frame_done.
  - Then frame 2 writes are accepted, and frame 1 data read back is intact.
- Concurrent streaming, IN 8x2, SX_LOG2=2, SY_LOG2=0:
  - Stimulus: interleaved writes and reads.
  - Required: the output row 0 column order is 0,0,0,0,1,…, and no element is dropped or duplicated.
- flush mid-frame:
  - Stimulus: assert flush after 5 writes and 2 reads.
  - Required: the next cycle has rd_ready=0 and rd_valid=0, and the next write goes to address 0.
